// File: rtl/riscv_pkg.sv
// Shared decode encodings for the RV32I pipeline: opcodes, ALU/result-select codes,
// immediate formats and the D/E pipeline register layout.
package riscv_pkg;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_ctl_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_e;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } imm_src_e;

   typedef struct packed {
      logic        reg_write;
      result_src_e result_src;
      logic        mem_write;
      logic        jump;
      logic        branch;
      alu_ctl_e    alu_ctl;
      logic        alu_src;
      imm_src_e    imm_src;
      logic        has_imm;
   } ctrl_t;

   typedef struct packed {
      logic        reg_write;
      result_src_e result_src;
      logic        mem_write;
      logic        jump;
      logic        branch;
      alu_ctl_e    alu_ctl;
      logic        alu_src;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] pc4;
   } de_reg_t;

   // funct3 to ALU op; sub only applies to the R-type add slot
   function automatic alu_ctl_e alu_dec(input logic [2:0] funct3, input logic sub);
      alu_ctl_e op;
      case (funct3)
         3'b000:  op = sub ? ALU_SUB : ALU_ADD;
         3'b010:  op = ALU_SLT;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   function automatic logic [31:0] imm_ext(input logic [31:0] instr, input imm_src_e src);
      logic [31:0] imm;
      case (src)
         IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         default: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two combinational reads, one write, async clear,
// x0 hardwired to zero and same-cycle write-to-read bypass.
module reg_file #(
   parameter int NREGS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);

   logic [31:0] regs [NREGS];
   logic        wr_en;

   assign wr_en = we && (wa != 5'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[wa] <= wd;
      end
   end

   // Bypass lets decode see a writeback landing on the same edge it captures
   always_comb begin
      rd1 = '0;
      if (ra1 != 5'd0) rd1 = (wr_en && wa == ra1) ? wd : regs[ra1];
   end

   always_comb begin
      rd2 = '0;
      if (ra2 != 5'd0) rd2 = (wr_en && wa == ra2) ? wd : regs[ra2];
   end

endmodule

// File: rtl/decode_stage.sv
// RISC-V decode stage: control decode, register read, immediate extension and
// the D/E pipeline register feeding execute.
module decode_stage
   import riscv_pkg::*;
#(
   parameter int NREGS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] InstrD,
   input  logic [31:0] PCD,
   input  logic [31:0] PCPlus4D,
   input  logic        RegWriteW,
   input  logic [4:0]  RdW,
   input  logic [31:0] ResultW,
   input  logic        FlushE,
   output logic        RegWriteE,
   output logic [1:0]  ResultSrcE,
   output logic        MemWriteE,
   output logic        JumpE,
   output logic        BranchE,
   output logic [2:0]  ALUControlE,
   output logic        ALUSrcE,
   output logic [31:0] RD1E,
   output logic [31:0] RD2E,
   output logic [31:0] ImmExtE,
   output logic [4:0]  Rs1E,
   output logic [4:0]  Rs2E,
   output logic [4:0]  RdE,
   output logic [31:0] PCE,
   output logic [31:0] PCPlus4E
);

   ctrl_t       ctl;
   de_reg_t     de_d, de_q;
   logic [31:0] rd1, rd2;
   logic [6:0]  opcode;
   logic [2:0]  funct3;

   assign opcode = InstrD[6:0];
   assign funct3 = InstrD[14:12];

   reg_file #(.NREGS(NREGS)) u_rf (
      .clk (clk),
      .rst (rst),
      .ra1 (InstrD[19:15]),
      .ra2 (InstrD[24:20]),
      .we  (RegWriteW),
      .wa  (RdW),
      .wd  (ResultW),
      .rd1 (rd1),
      .rd2 (rd2)
   );

   // Anything not listed, including the all-zero fetch bubble, leaves controls at 0
   always_comb begin
      ctl = '0;
      case (opcode)
         OP_LW: begin
            ctl.reg_write  = 1'b1;
            ctl.result_src = RES_MEM;
            ctl.alu_src    = 1'b1;
            ctl.imm_src    = IMM_I;
            ctl.has_imm    = 1'b1;
         end
         OP_SW: begin
            ctl.mem_write = 1'b1;
            ctl.alu_src   = 1'b1;
            ctl.imm_src   = IMM_S;
            ctl.has_imm   = 1'b1;
         end
         OP_R: begin
            ctl.reg_write = 1'b1;
            ctl.alu_ctl   = alu_dec(funct3, InstrD[30]);
         end
         OP_I: begin
            ctl.reg_write = 1'b1;
            ctl.alu_ctl   = alu_dec(funct3, 1'b0);
            ctl.alu_src   = 1'b1;
            ctl.imm_src   = IMM_I;
            ctl.has_imm   = 1'b1;
         end
         OP_BEQ: begin
            ctl.branch  = 1'b1;
            ctl.alu_ctl = ALU_SUB;
            ctl.imm_src = IMM_B;
            ctl.has_imm = 1'b1;
         end
         OP_JAL: begin
            ctl.reg_write  = 1'b1;
            ctl.jump       = 1'b1;
            ctl.result_src = RES_PC4;
            ctl.imm_src    = IMM_J;
            ctl.has_imm    = 1'b1;
         end
         default: ctl = '0;
      endcase
   end

   always_comb begin
      de_d            = '0;
      de_d.reg_write  = ctl.reg_write;
      de_d.result_src = ctl.result_src;
      de_d.mem_write  = ctl.mem_write;
      de_d.jump       = ctl.jump;
      de_d.branch     = ctl.branch;
      de_d.alu_ctl    = ctl.alu_ctl;
      de_d.alu_src    = ctl.alu_src;
      de_d.rd1        = rd1;
      de_d.rd2        = rd2;
      de_d.imm        = ctl.has_imm ? imm_ext(InstrD, ctl.imm_src) : 32'd0;
      de_d.rs1        = InstrD[19:15];
      de_d.rs2        = InstrD[24:20];
      de_d.rd         = InstrD[11:7];
      de_d.pc         = PCD;
      de_d.pc4        = PCPlus4D;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        de_q <= '0;
      else if (FlushE) de_q <= '0;
      else             de_q <= de_d;
   end

   assign RegWriteE   = de_q.reg_write;
   assign ResultSrcE  = de_q.result_src;
   assign MemWriteE   = de_q.mem_write;
   assign JumpE       = de_q.jump;
   assign BranchE     = de_q.branch;
   assign ALUControlE = de_q.alu_ctl;
   assign ALUSrcE     = de_q.alu_src;
   assign RD1E        = de_q.rd1;
   assign RD2E        = de_q.rd2;
   assign ImmExtE     = de_q.imm;
   assign Rs1E        = de_q.rs1;
   assign Rs2E        = de_q.rs2;
   assign RdE         = de_q.rd;
   assign PCE         = de_q.pc;
   assign PCPlus4E    = de_q.pc4;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: instruction-level reference model checked every cycle,
// plus directed literal expectations that pin the model.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
   logic        RegWriteW, FlushE;
   logic [4:0]  RdW;
   logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
   logic [1:0]  ResultSrcE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
   logic [4:0]  Rs1E, Rs2E, RdE;

   int vectors = 0;
   int miscompares = 0;
   logic cmp_en = 1'b0;
   logic [31:0] pc = 32'd0;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
      .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
      .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
      .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .PCE(PCE), .PCPlus4E(PCPlus4E)
   );

   typedef struct packed {
      logic        regw;
      logic [1:0]  rsrc;
      logic        memw;
      logic        jump;
      logic        branch;
      logic [2:0]  alu;
      logic        alusrc;
      logic [31:0] rd1, rd2, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] pc, pc4;
   } exp_t;

   exp_t        expd;
   logic [31:0] mregs [32];

   // ALU code per funct3 for the supported add/slt/or/and slots
   function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub);
      case (f3)
         3'd0:    return sub ? 3'd1 : 3'd0;
         3'd2:    return 3'd5;
         3'd6:    return 3'd3;
         3'd7:    return 3'd2;
         default: return 3'd0;
      endcase
   endfunction

   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] p4,
                                  input logic [31:0] r1, input logic [31:0] r2);
      exp_t e;
      int   imm;
      e = '0;
      imm = 0;
      e.rd1 = r1; e.rd2 = r2;
      e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
      e.pc = p; e.pc4 = p4;
      case (ins[6:0])
         7'h03: begin
            e.regw = 1'b1; e.rsrc = 2'd1; e.alusrc = 1'b1;
            imm = int'($signed(ins[31:20]));
         end
         7'h23: begin
            e.memw = 1'b1; e.alusrc = 1'b1;
            imm = int'($signed({ins[31:25], ins[11:7]}));
         end
         7'h33: begin
            e.regw = 1'b1; e.alu = alu_of(ins[14:12], ins[30]);
         end
         7'h13: begin
            e.regw = 1'b1; e.alusrc = 1'b1; e.alu = alu_of(ins[14:12], 1'b0);
            imm = int'($signed(ins[31:20]));
         end
         7'h63: begin
            e.branch = 1'b1; e.alu = 3'd1;
            imm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
         end
         7'h6F: begin
            e.regw = 1'b1; e.jump = 1'b1; e.rsrc = 2'd2;
            imm = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
         end
         default: imm = 0;
      endcase
      e.imm = 32'(imm);
      return e;
   endfunction

   function automatic logic [31:0] mread(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (RegWriteW && RdW == a) return ResultW;
      return mregs[a];
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         expd <= '0;
         for (int i = 0; i < 32; i++) mregs[i] <= 32'd0;
      end else begin
         expd <= FlushE ? '0 : model(InstrD, PCD, PCPlus4D, mread(InstrD[19:15]), mread(InstrD[24:20]));
         if (RegWriteW && RdW != 5'd0) mregs[RdW] <= ResultW;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("RegWriteE", 32'(RegWriteE), 32'(expd.regw));
         chk("ResultSrcE", 32'(ResultSrcE), 32'(expd.rsrc));
         chk("MemWriteE", 32'(MemWriteE), 32'(expd.memw));
         chk("JumpE", 32'(JumpE), 32'(expd.jump));
         chk("BranchE", 32'(BranchE), 32'(expd.branch));
         chk("ALUControlE", 32'(ALUControlE), 32'(expd.alu));
         chk("ALUSrcE", 32'(ALUSrcE), 32'(expd.alusrc));
         chk("RD1E", RD1E, expd.rd1);
         chk("RD2E", RD2E, expd.rd2);
         chk("ImmExtE", ImmExtE, expd.imm);
         chk("Rs1E", 32'(Rs1E), 32'(expd.rs1));
         chk("Rs2E", 32'(Rs2E), 32'(expd.rs2));
         chk("RdE", 32'(RdE), 32'(expd.rd));
         chk("PCE", PCE, expd.pc);
         chk("PCPlus4E", PCPlus4E, expd.pc4);
      end
   end

   task automatic step(input logic [31:0] ins, input logic we, input logic [4:0] rdw,
                       input logic [31:0] res, input logic fl);
      @(negedge clk);
      InstrD = ins; RegWriteW = we; RdW = rdw; ResultW = res; FlushE = fl;
      PCD = pc; PCPlus4D = pc + 32'd1; pc = pc + 32'd1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      InstrD = '0; PCD = '0; PCPlus4D = '0; RegWriteW = 1'b0; RdW = '0; ResultW = '0; FlushE = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("init_RegWriteE", 32'(RegWriteE), 32'd0);
      chk("init_PCE", PCE, 32'd0);
      @(negedge clk) rst = 1'b1;

      // Preload operands through writeback with fetch bubbles in decode
      step(32'h0, 1'b1, 5'd8, 32'h100, 1'b0);
      cmp_en = 1'b1;
      step(32'h0, 1'b1, 5'd6, 32'h0000_0030, 1'b0);
      step(32'h0, 1'b1, 5'd24, 32'h0000_0010, 1'b0);
      step(32'h0, 1'b1, 5'd29, 32'h0000_2000, 1'b0);
      step(32'h0, 1'b1, 5'd22, 32'h6666_0006, 1'b0);
      step(32'h0, 1'b1, 5'd5, 32'h0000_1234, 1'b0);

      step(32'h02842903, 1'b0, 5'd0, 32'h0, 1'b0);  // lw s2,40(s0)
      chk("lw_RegWriteE", 32'(RegWriteE), 32'd1);
      chk("lw_ResultSrcE", 32'(ResultSrcE), 32'd1);
      chk("lw_ALUSrcE", 32'(ALUSrcE), 32'd1);
      chk("lw_ImmExtE", ImmExtE, 32'h28);
      chk("lw_RD1E", RD1E, 32'h100);
      chk("lw_RdE", 32'(RdE), 32'd18);

      step(32'h41830A33, 1'b0, 5'd0, 32'h0, 1'b0);  // sub s4,t1,s8
      chk("sub_ALUControlE", 32'(ALUControlE), 32'd1);
      chk("sub_Rs1E", 32'(Rs1E), 32'd6);
      chk("sub_Rs2E", 32'(Rs2E), 32'd24);
      chk("sub_RdE", 32'(RdE), 32'd20);
      chk("sub_ALUSrcE", 32'(ALUSrcE), 32'd0);

      step(32'h016EAA23, 1'b0, 5'd0, 32'h0, 1'b0);  // sw s6,20(t4)
      chk("sw_MemWriteE", 32'(MemWriteE), 32'd1);
      chk("sw_RegWriteE", 32'(RegWriteE), 32'd0);
      chk("sw_ImmExtE", ImmExtE, 32'h14);
      chk("sw_Rs2E", 32'(Rs2E), 32'd22);

      step(32'h01AC89B3, 1'b1, 5'd25, 32'hDEADBEEF, 1'b0);  // add s3,s9,s10 with bypass on rs1
      chk("byp1_RD1E", RD1E, 32'hDEADBEEF);
      step(32'h01AC89B3, 1'b1, 5'd26, 32'h0000_0011, 1'b0);  // bypass on rs2
      chk("byp2_RD2E", RD2E, 32'h0000_0011);
      chk("byp2_RD1E", RD1E, 32'hDEADBEEF);

      step(32'h00000033, 1'b1, 5'd0, 32'h55, 1'b0);  // write to x0 while reading x0
      chk("x0_byp_RD1E", RD1E, 32'd0);
      step(32'h00000033, 1'b0, 5'd0, 32'h0, 1'b0);
      chk("x0_RD1E", RD1E, 32'd0);

      step(32'h01AC89B3, 1'b1, 5'd7, 32'h0000_CAFE, 1'b1);  // flush with valid add
      chk("flush_RegWriteE", 32'(RegWriteE), 32'd0);
      chk("flush_RD1E", RD1E, 32'd0);
      chk("flush_RdE", 32'(RdE), 32'd0);
      chk("flush_PCE", PCE, 32'd0);
      step(32'h000380B3, 1'b0, 5'd0, 32'h0, 1'b0);  // add ra,t2,x0
      chk("flush_wr_RD1E", RD1E, 32'h0000_CAFE);

      step(32'hFE208CE3, 1'b0, 5'd0, 32'h0, 1'b0);  // beq ra,sp,-8
      chk("beq_BranchE", 32'(BranchE), 32'd1);
      chk("beq_ImmExtE", ImmExtE, 32'hFFFF_FFF8);
      step(32'h010000EF, 1'b0, 5'd0, 32'h0, 1'b0);  // jal ra,16
      chk("jal_JumpE", 32'(JumpE), 32'd1);
      chk("jal_ResultSrcE", 32'(ResultSrcE), 32'd2);
      chk("jal_ImmExtE", ImmExtE, 32'h10);
      step(32'hFFF00193, 1'b0, 5'd0, 32'h0, 1'b0);  // addi gp,x0,-1
      chk("addi_ImmExtE", ImmExtE, 32'hFFFF_FFFF);
      step(32'h40046213, 1'b0, 5'd0, 32'h0, 1'b0);  // ori tp,s0,0x400 (bit30 set, not sub)
      chk("ori_ALUControlE", 32'(ALUControlE), 32'd3);
      step(32'hFFD32293, 1'b0, 5'd0, 32'h0, 1'b0);  // slti t0,t1,-3
      step(32'h0FF4F393, 1'b0, 5'd0, 32'h0, 1'b0);  // andi t2,s1,0xff
      step(32'h00C5F533, 1'b0, 5'd0, 32'h0, 1'b0);  // and
      step(32'h00C5E533, 1'b0, 5'd0, 32'h0, 1'b0);  // or
      step(32'h00C5A533, 1'b0, 5'd0, 32'h0, 1'b0);  // slt
      step(32'hFE112E23, 1'b0, 5'd0, 32'h0, 1'b0);  // sw ra,-4(sp)
      step(32'h00000037, 1'b0, 5'd0, 32'h0, 1'b0);  // lui: unsupported
      chk("unsup_RegWriteE", 32'(RegWriteE), 32'd0);
      chk("unsup_ImmExtE", ImmExtE, 32'd0);
      step(32'h000280B3, 1'b0, 5'd0, 32'h0, 1'b0);  // read x5 before reset
      chk("pre_rst_x5", RD1E, 32'h0000_1234);

      // Mid-run async reset with a write requested while held
      rst = 1'b0;
      #1;
      chk("rst_RegWriteE", 32'(RegWriteE), 32'd0);
      chk("rst_RD1E", RD1E, 32'd0);
      chk("rst_PCE", PCE, 32'd0);
      chk("rst_RdE", 32'(RdE), 32'd0);
      RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'h0000_0BAD;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1; RegWriteW = 1'b0;
      step(32'h000280B3, 1'b0, 5'd0, 32'h0, 1'b0);
      chk("post_rst_x5", RD1E, 32'd0);
      step(32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Decode stage of the five-stage RISC-V pipeline, directly downstream of fetch. It consumes the fetched instruction, PC and PC+1 each cycle, and decodes the control fields. It reads operands from an internal 32x32 register file, which writeback also updates, and extends the immediate. All results are registered into the D/E pipeline register that feeds execute.

## Interface
- Parameters:
  - `NREGS`, default 32: number of architectural registers (x0 hardwired zero).
- Clock and reset (already decided): reset `rst`, asynchronous, active-low; clock `clk`.
- Inputs:
  - `InstrD` in 32: instruction from fetch.
  - `PCD` in 32: word address of `InstrD`.
  - `PCPlus4D` in 32: next word address (PC+1).
  - `RegWriteW` in 1: writeback write enable.
  - `RdW` in 5: writeback destination register.
  - `ResultW` in 32: writeback data.
  - `FlushE` in 1: active-high synchronous bubble insert into E.
- Control outputs to execute:
  - `RegWriteE` out 1.
  - `ResultSrcE` out 2: 00 ALU, 01 memory, 10 PC+1.
  - `MemWriteE` out 1.
  - `JumpE` out 1.
  - `BranchE` out 1.
  - `ALUControlE` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
  - `ALUSrcE` out 1: 1 selects the immediate.
- Data outputs to execute:
  - `RD1E`, `RD2E` out 32: register operands.
  - `ImmExtE` out 32: sign-extended immediate, in bytes per ISA. Execute does any scaling.
  - `Rs1E`, `Rs2E`, `RdE` out 5: register indices, for the hazard unit.
  - `PCE`, `PCPlus4E` out 32: passed through.

## Operation
- Decoding uses opcode `InstrD[6:0]`, funct3 `[14:12]` and funct7 bit 5 `[30]`. Supported instructions:
  - lw (0000011): RegWrite, ResultSrc=01, ALUSrc, add, I-immediate.
  - sw (0100011): MemWrite, ALUSrc, add, S-immediate.
  - R-type (0110011): RegWrite, ALU ops add/sub/and/or/slt. sub when funct7[5]=1 and funct3=000.
  - I-ALU (0010011): addi/andi/ori/slti, ALUSrc, I-immediate. funct7 is ignored.
  - beq (1100011): Branch, sub, B-immediate.
  - jal (1101111): RegWrite, Jump, ResultSrc=10, J-immediate.
- Unsupported opcodes, and all-zero `InstrD` (bubble from fetch), decode to all control bits 0.
- Immediates are built from `InstrD` bit fields per the RV32I formats. Bit 31 is always the sign bit.
- Register file:
  - 2 combinational read ports (rs1=`InstrD[19:15]`, rs2=`InstrD[24:20]`) and 1 write port.
  - Writes happen at posedge `clk` when `RegWriteW`=1 and `RdW`≠0.
  - x0 always reads 0.
  - Internal bypass: if `RegWriteW`=1, `RdW`≠0 and `RdW` equals a read index, that port returns `ResultW` in the same cycle.
- Pipeline register:
  - Captures all decoded controls, operands, immediate, indices and PCs at posedge `clk`.
  - With `FlushE`=1, every E output is loaded with 0 instead. The register file write still occurs.

## Timing
- Decode and register read are combinational from `InstrD` and reg-file state. The E outputs appear 1 cycle after `InstrD` is presented.
- Asynchronous reset (`rst`=0): all E outputs go to 0 and all 32 registers go to 0 immediately, independent of `clk`.
  - Writes requested during reset are dropped.
  - The first edge after deassertion operates normally.
- If `FlushE` and a valid `InstrD` arrive in the same cycle, flush wins: the E outputs are 0.
- A write to register r at edge n, with r read in the same cycle: `RDxE` shows `ResultW` at edge n, via the bypass.
- `RdW`=0 with `RegWriteW`=1: no state change, and the bypass is not applied.

## Structure
- Shared package `riscv_pkg` holds:
  - opcode constants: OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL;
  - the ALUControl encoding;
  - the ResultSrc encoding;
  - the ImmSrc encoding: I/S/B/J.
- One sub-module: `reg_file`, with the 2R/1W array, async clear, x0 rule and write bypass.
- Control decode, immediate extension and the D/E register are inline in `decode_stage`.

## Test plan
- Reset: assert `rst`=0 mid-run, then release. All E outputs read 0, and after release x5 reads 0.
- lw s2,40(s0): `InstrD`=0x02842903 with s0 holding 0x100. Next edge:
  - `RegWriteE`=1, `ResultSrcE`=01, `ALUSrcE`=1;
  - `ImmExtE`=0x28, `RD1E`=0x100, `RdE`=18.
- sub s4,t1,s8: `InstrD`=0x41830A33. Next edge: `ALUControlE`=001, `Rs1E`=6, `Rs2E`=24, `RdE`=20, `ALUSrcE`=0.
- sw s6,20(t4): `InstrD`=0x016EAA23. Next edge: `MemWriteE`=1, `RegWriteE`=0, `ImmExtE`=0x14, `Rs2E`=22.
- Bypass: `RegWriteW`=1, `RdW`=25, `ResultW`=0xDEADBEEF, with `InstrD`=0x01AC89B3 (add s3,s9,s10) in the same cycle. Next edge: `RD1E`=0xDEADBEEF.
- x0 and flush:
  - A write of 0x55 to x0 leaves reads of x0 at 0.
  - `FlushE`=1 with a valid add: all E outputs are 0 next edge, and the simultaneous W write is still committed.
